inv_lshr_sgt_checker: RTL and testbench

//  Consumes the Skolem candidate for the invertibility condition of (x >>u s) >s t and certifies it.
//  Per transaction {s,t,x_cand}: evaluate candidate; if it fails, exhaustively search all 2^W x.

---
 rtl/inv_check_pkg.sv | 39 +++
 rtl/inv_cond_eval.sv | 15 +
 rtl/inv_lshr_sgt_checker.sv | 162 ++++++++++++++++
 tb/tb_inv_lshr_sgt_checker.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/inv_check_pkg.sv
// Shared types and the shift/compare predicate for the invertibility checker.
package inv_check_pkg;

    localparam int W_MAX = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_e;

    // P(x,s,t) = ((s >= w) ? 0 : x >>u s) >s t, evaluated at width w.
    // Operands arrive zero-extended to W_MAX. The signed compare is done as an
    // unsigned compare after flipping bit w-1 of both sides.
    function automatic logic lshr_sgt(input logic [W_MAX-1:0] x,
                                      input logic [W_MAX-1:0] s,
                                      input logic [W_MAX-1:0] t,
                                      input int               w);
        logic [W_MAX-1:0] one;
        logic [W_MAX-1:0] msk;
        logic [W_MAX-1:0] sgn;
        logic [W_MAX-1:0] sh;
        one = {{(W_MAX-1){1'b0}}, 1'b1};
        if (w >= W_MAX) begin
            msk = {W_MAX{1'b1}};
        end else begin
            msk = (one << w) - one;
        end
        sgn = one << (w - 1);
        if (s >= W_MAX'(w)) begin
            sh = {W_MAX{1'b0}};
        end else begin
            sh = (x >> s) & msk;
        end
        return ((sh ^ sgn) & msk) > ((t ^ sgn) & msk);
    endfunction

endpackage

// File: rtl/inv_cond_eval.sv
// Combinational evaluation of the predicate P(x,s,t) at width W.
module inv_cond_eval
    import inv_check_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] s_i,
    input  logic [W-1:0] t_i,
    output logic         p_o
);

    assign p_o = lshr_sgt(W_MAX'(x_i), W_MAX'(s_i), W_MAX'(t_i), W);

endmodule

// File: rtl/inv_lshr_sgt_checker.sv
// Certifies a Skolem candidate for (x >>u s) >s t; on failure sweeps all x
// to decide whether a valid x exists, and keeps saturating statistics.
module inv_lshr_sgt_checker
    import inv_check_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s_in,
    input  logic [W-1:0]     t_in,
    input  logic [W-1:0]     x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cand_ok,
    output logic             exists,
    output logic [W-1:0]     witness,
    output logic             mismatch,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    state_e             state_q, state_d;
    logic [W-1:0]       s_q, s_d, t_q, t_d, x_q, x_d, cnt_q, cnt_d;
    logic               cand_ok_q, cand_ok_d, exists_q, exists_d;
    logic               mismatch_q, mismatch_d;
    logic [W-1:0]       witness_q, witness_d;
    logic [CNT_W-1:0]   txn_q, txn_d, err_q, err_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic               p_cand_s, p_cnt_s;

    inv_cond_eval #(.W(W)) u_eval_cand (
        .x_i (x_q), .s_i (s_q), .t_i (t_q), .p_o (p_cand_s)
    );

    inv_cond_eval #(.W(W)) u_eval_cnt (
        .x_i (cnt_q), .s_i (s_q), .t_i (t_q), .p_o (p_cnt_s)
    );

    // Next-state, datapath and statistics update for the checker FSM.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        t_d        = t_q;
        x_d        = x_q;
        cnt_d      = cnt_q;
        cand_ok_d  = cand_ok_q;
        exists_d   = exists_q;
        witness_d  = witness_q;
        mismatch_d = mismatch_q;
        txn_d      = txn_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = s_in;
                    t_d     = t_in;
                    x_d     = x_in;
                    state_d = EVAL;
                end else begin
                    state_d = IDLE;
                end
            end
            EVAL: begin
                cand_ok_d = p_cand_s;
                if (p_cand_s) begin
                    exists_d   = 1'b1;
                    witness_d  = x_q;
                    mismatch_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    cnt_d   = {W{1'b0}};
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (p_cnt_s) begin
                    // Candidate already failed, so any hit is a mismatch.
                    exists_d   = 1'b1;
                    witness_d  = cnt_q;
                    mismatch_d = ~cand_ok_q;
                    state_d    = DONE;
                end else if (cnt_q == {W{1'b1}}) begin
                    exists_d   = 1'b0;
                    witness_d  = {W{1'b0}};
                    mismatch_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (txn_q != {CNT_W{1'b1}}) begin
                        txn_d = txn_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        txn_d = txn_q;
                    end
                    if (mismatch_q && (err_q != {CNT_W{1'b1}})) begin
                        err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        err_d = err_q;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, operand, result and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= {W{1'b0}};
            t_q         <= {W{1'b0}};
            x_q         <= {W{1'b0}};
            cnt_q       <= {W{1'b0}};
            cand_ok_q   <= 1'b0;
            exists_q    <= 1'b0;
            witness_q   <= {W{1'b0}};
            mismatch_q  <= 1'b0;
            txn_q       <= {CNT_W{1'b0}};
            err_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            t_q         <= t_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            cand_ok_q   <= cand_ok_d;
            exists_q    <= exists_d;
            witness_q   <= witness_d;
            mismatch_q  <= mismatch_d;
            txn_q       <= txn_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign cand_ok   = cand_ok_q;
    assign exists    = exists_q;
    assign witness   = witness_q;
    assign mismatch  = mismatch_q;
    assign txn_count = txn_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_inv_lshr_sgt_checker.sv
// Randomized plus directed bench for inv_lshr_sgt_checker (W=4) against an
// arithmetic reference model.
module tb_inv_lshr_sgt_checker;

    localparam int W     = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]     s_in, t_in, x_in, witness;
    logic             cand_ok, exists, mismatch;
    logic [CNT_W-1:0] txn_count, err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_txn = 0;
    int exp_err = 0;

    inv_lshr_sgt_checker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s_in(s_in), .t_in(t_in), .x_in(x_in), .out_valid(out_valid),
        .out_ready(out_ready), .cand_ok(cand_ok), .exists(exists),
        .witness(witness), .mismatch(mismatch), .txn_count(txn_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference predicate with plain integer arithmetic.
    function automatic bit ref_p(input int x, input int s, input int t);
        int sh, sv, tv;
        sh = (s >= W) ? 0 : (x >> s);
        sv = (sh >= (1 << (W-1))) ? sh - (1 << W) : sh;
        tv = (t  >= (1 << (W-1))) ? t  - (1 << W) : t;
        return sv > tv;
    endfunction

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"},  int'(in_ready), 1);
        check_val({tag, "_out_valid"}, int'(out_valid), 0);
        check_val({tag, "_cand_ok"},   int'(cand_ok), 0);
        check_val({tag, "_exists"},    int'(exists), 0);
        check_val({tag, "_witness"},   int'(witness), 0);
        check_val({tag, "_mismatch"},  int'(mismatch), 0);
        check_val({tag, "_txn"},       int'(txn_count), 0);
        check_val({tag, "_err"},       int'(err_count), 0);
    endtask

    // One transaction: edges from acceptance to first out_valid, results,
    // optional DONE stall, then handshake and counter check.
    task automatic do_txn(input int s, input int t, input int x, input int stall);
        bit e_cand, e_exists, e_mis;
        int e_wit, e_lat, edges;
        e_cand = ref_p(x, s, t);
        e_exists = 1'b0;
        e_wit = 0;
        e_lat = 1 + (1 << W);
        if (e_cand) begin
            e_exists = 1'b1; e_wit = x; e_lat = 1;
        end else begin
            for (int k = 0; k < (1 << W); k++) begin
                if (!e_exists && ref_p(k, s, t)) begin
                    e_exists = 1'b1; e_wit = k; e_lat = 2 + k;
                end
            end
        end
        e_mis = e_exists && !e_cand;

        @(negedge clk);
        check_val("idle_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        s_in = W'(s); t_in = W'(t); x_in = W'(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check_val("latency",  edges, e_lat);
        check_val("cand_ok",  int'(cand_ok), int'(e_cand));
        check_val("exists",   int'(exists), int'(e_exists));
        check_val("witness",  int'(witness), e_wit);
        check_val("mismatch", int'(mismatch), int'(e_mis));
        check_val("busy_in_ready", int'(in_ready), 0);

        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            s_in = W'($urandom); t_in = W'($urandom); x_in = W'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check_val("stall_valid",   int'(out_valid), 1);
            check_val("stall_ready",   int'(in_ready), 0);
            check_val("stall_witness", int'(witness), e_wit);
            check_val("stall_exists",  int'(exists), int'(e_exists));
            check_val("stall_txn",     int'(txn_count), exp_txn);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_txn++;
        if (e_mis) exp_err++;
        check_val("post_valid", int'(out_valid), 0);
        check_val("post_ready", int'(in_ready), 1);
        check_val("txn_count",  int'(txn_count), exp_txn);
        check_val("err_count",  int'(err_count), exp_err);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        s_in = '0; t_in = '0; x_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        do_txn(0, 8, 0, 0);
        do_txn(1, 0, 0, 0);
        do_txn(0, 7, 5, 0);
        do_txn(4, 15, 9, 0);
        do_txn(4, 0, 3, 0);
        do_txn(2, 1, 1, 3);

        // Reset during the sweep abandons the transaction.
        @(negedge clk);
        in_valid = 1'b1; s_in = 4'd0; t_in = 4'd7; x_in = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_txn = 0; exp_err = 0;
        check_reset_state("midsearch_rst");
        do_txn(1, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            do_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), (i % 7 == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
